// File: rtl/fetch_queue.sv
// Instruction-fetch stage: fetch PC, 1-cycle imem read, prefetch queue toward decode.
// Optional FETCH_STATS_EN adds saturating popped/flushed counters.
module fetch_queue #(
   parameter int unsigned        ADDR_W   = 16,
   parameter int unsigned        INSTR_W  = 16,
   parameter int unsigned        DEPTH    = 4,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               halt,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic [ADDR_W-1:0]  instr_pc_plus1,
   output logic               halted
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0]        stat_fetched,
   output logic [31:0]        stat_flushed
`endif
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned OCC_W = CNT_W + 1;

   typedef enum logic [0:0] {StRun, StHalted} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0]   resp_pc_q;
   logic                inflight_q;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [OCC_W-1:0]    occupancy;
   logic                issue, push, pop, valid;

   logic [INSTR_W-1:0]  instr_mem [DEPTH];
   logic [ADDR_W-1:0]   pc_mem [DEPTH];

   // Counting the in-flight read against capacity guarantees a push always has room.
   assign occupancy = OCC_W'(count_q) + OCC_W'(inflight_q);
   // rst gates issue so no request is seen while reset is held.
   assign issue = rst & (state_q == StRun) & ~halt & ~redirect & (occupancy < OCC_W'(DEPTH));
   assign valid = (count_q != '0);
   assign pop   = valid & instr_ready;
   assign push  = inflight_q & ~redirect;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StRun:    if (halt) state_d = StHalted;
         StHalted: if (!halt || redirect) state_d = StRun;
         default:  state_d = StRun;
      endcase
   end

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      if (redirect) begin
         fetch_pc_d = redirect_pc;
      end else if (issue) begin
         fetch_pc_d = fetch_pc_q + ADDR_W'(1);
      end
   end

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (redirect) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
         end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StRun;
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= '0;
         inflight_q <= 1'b0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         inflight_q <= issue;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         if (issue) resp_pc_q <= fetch_pc_q;
      end
   end

   // Entry storage needs no reset: head outputs are masked while the queue is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem[wr_ptr_q] <= imem_rdata;
         pc_mem[wr_ptr_q]    <= resp_pc_q;
      end
   end

   assign imem_req       = issue;
   assign imem_addr      = fetch_pc_q;
   assign instr_valid    = valid;
   assign instr          = valid ? instr_mem[rd_ptr_q] : '0;
   assign instr_pc       = valid ? pc_mem[rd_ptr_q] : '0;
   assign instr_pc_plus1 = valid ? pc_mem[rd_ptr_q] + ADDR_W'(1) : '0;
   assign halted         = (state_q == StHalted) & ~valid & ~inflight_q;

`ifdef FETCH_STATS_EN
   logic [31:0]      fetched_q, fetched_d;
   logic [31:0]      flushed_q, flushed_d;
   logic [OCC_W-1:0] flush_inc;
   logic [32:0]      flush_sum;

   // An entry popped in the redirect cycle was delivered, so it is not counted as flushed.
   always_comb begin
      flush_inc = '0;
      if (redirect) begin
         flush_inc = OCC_W'(count_q) - OCC_W'(pop) + OCC_W'(inflight_q);
      end
      flush_sum = {1'b0, flushed_q} + 33'(flush_inc);
      flushed_d = flush_sum[32] ? '1 : flush_sum[31:0];
      fetched_d = fetched_q;
      if (pop && (fetched_q != '1)) fetched_d = fetched_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetched_q <= '0;
         flushed_q <= '0;
      end else begin
         fetched_q <= fetched_d;
         flushed_q <= flushed_d;
      end
   end

   assign stat_fetched = fetched_q;
   assign stat_flushed = flushed_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming, back-pressure, redirect, halt, PC wrap, reset.
// A second instance with RESET_PC=16'hFFFE runs free to exercise PC wrap-around.
module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        halt = 1'b0;
   logic        redirect = 1'b0;
   logic [15:0] redirect_pc = '0;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic [15:0] imem_rdata = '0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [15:0] instr;
   logic [15:0] instr_pc;
   logic [15:0] instr_pc_plus1;
   logic        halted;

   logic        halt2 = 1'b0;
   logic        redirect2 = 1'b0;
   logic [15:0] redirect_pc2 = '0;
   logic        imem_req2;
   logic [15:0] imem_addr2;
   logic [15:0] imem_rdata2 = '0;
   logic        instr_valid2;
   logic        instr_ready2 = 1'b1;
   logic [15:0] instr2;
   logic [15:0] instr_pc2;
   logic [15:0] instr_pc_plus1_2;
   logic        halted2;

`ifdef FETCH_STATS_EN
   logic [31:0] stat_fetched, stat_flushed, stat_fetched2, stat_flushed2;
`endif

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   // Memory returns its address as data, one cycle later.
   always @(posedge clk) begin
      imem_rdata  <= imem_addr;
      imem_rdata2 <= imem_addr2;
   end

   fetch_queue #(.ADDR_W(16), .INSTR_W(16), .DEPTH(4), .RESET_PC(16'h0000)) dut (
      .clk(clk), .rst(rst), .halt(halt), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .instr_pc(instr_pc), .instr_pc_plus1(instr_pc_plus1), .halted(halted)
`ifdef FETCH_STATS_EN
      , .stat_fetched(stat_fetched), .stat_flushed(stat_flushed)
`endif
   );

   fetch_queue #(.ADDR_W(16), .INSTR_W(16), .DEPTH(4), .RESET_PC(16'hFFFE)) dut2 (
      .clk(clk), .rst(rst), .halt(halt2), .redirect(redirect2), .redirect_pc(redirect_pc2),
      .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
      .instr_valid(instr_valid2), .instr_ready(instr_ready2), .instr(instr2),
      .instr_pc(instr_pc2), .instr_pc_plus1(instr_pc_plus1_2), .halted(halted2)
`ifdef FETCH_STATS_EN
      , .stat_fetched(stat_fetched2), .stat_flushed(stat_flushed2)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " req"},   32'(imem_req), 32'd0);
      check({tag, " valid"}, 32'(instr_valid), 32'd0);
      check({tag, " halted"}, 32'(halted), 32'd0);
      check({tag, " instr"}, 32'(instr), 32'd0);
      check({tag, " pc"},    32'(instr_pc), 32'd0);
      check({tag, " pc1"},   32'(instr_pc_plus1), 32'd0);
   endtask

   // Holds reset for a cycle, checks reset outputs, then releases at a negedge (cycle 0).
   task automatic start_run(input logic rdy);
      rst = 1'b0;
      halt = 1'b0;
      redirect = 1'b0;
      redirect_pc = '0;
      instr_ready = rdy;
      @(negedge clk);
      #1;
      check_reset_outputs("rst");
      check("rst addr", 32'(imem_addr), 32'd0);
      @(negedge clk);
      rst = 1'b1;
   endtask

   logic [15:0] wrap_pc [3];

   initial begin
      wrap_pc[0] = 16'hFFFE;
      wrap_pc[1] = 16'hFFFF;
      wrap_pc[2] = 16'h0000;

      // 1: streaming with ready=1, plus wrap-around on dut2
      start_run(1'b1);
      for (int k = 0; k < 6; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         check("t1 req", 32'(imem_req), 32'd1);
         check("t1 addr", 32'(imem_addr), 32'(k));
         if (k < 2) begin
            check("t1 valid", 32'(instr_valid), 32'd0);
         end else begin
            check("t1 valid", 32'(instr_valid), 32'd1);
            check("t1 instr", 32'(instr), 32'(k - 2));
            check("t1 pc", 32'(instr_pc), 32'(k - 2));
            check("t1 pc1", 32'(instr_pc_plus1), 32'(k - 1));
            if (k < 5) begin
               check("t5 pc", 32'(instr_pc2), 32'(wrap_pc[k-2]));
               if (k == 3) check("t5 pc1", 32'(instr_pc_plus1_2), 32'h0000);
            end
         end
      end
`ifdef FETCH_STATS_EN
      check("t1 fetched", stat_fetched, 32'd3);
`endif

      // 2: back-pressure fills exactly DEPTH entries, then drains in order
      start_run(1'b0);
      for (int k = 0; k < 15; k++) begin
         if (k > 0) @(negedge clk);
         if (k == 10) instr_ready = 1'b1;
         #1;
         if (k < 4) check("t2 req", 32'(imem_req), 32'd1);
         if (k >= 4 && k <= 10) check("t2 stall", 32'(imem_req), 32'd0);
         if (k == 5) check("t2 addr hold", 32'(imem_addr), 32'd4);
         if (k == 9) check("t2 head", 32'(instr), 32'd0);
         if (k == 11) check("t2 resume", 32'(imem_addr), 32'd4);
         if (k >= 10) begin
            check("t2 valid", 32'(instr_valid), 32'd1);
            check("t2 order", 32'(instr_pc), 32'(k - 10));
         end
      end

      // 3: redirect with 3 queued + 1 in flight, then back-to-back redirects
      start_run(1'b0);
      for (int k = 0; k < 14; k++) begin
         if (k > 0) @(negedge clk);
         redirect = (k == 4 || k == 9 || k == 10);
         redirect_pc = (k == 4) ? 16'h0040 : (k == 9) ? 16'h0100 : 16'h0200;
         #1;
         case (k)
            4: begin
               check("t3 req n", 32'(imem_req), 32'd0);
               check("t3 valid n", 32'(instr_valid), 32'd1);
            end
            5: begin
               check("t3 valid n1", 32'(instr_valid), 32'd0);
               check("t3 req n1", 32'(imem_req), 32'd1);
               check("t3 addr n1", 32'(imem_addr), 32'h40);
`ifdef FETCH_STATS_EN
               check("t3 flushed", stat_flushed, 32'd4);
`endif
            end
            6: check("t3 valid n2", 32'(instr_valid), 32'd0);
            7, 8: begin
               check("t3 valid n3", 32'(instr_valid), 32'd1);
               check("t3 pc n3", 32'(instr_pc), 32'h40);
               check("t3 instr n3", 32'(instr), 32'h40);
            end
            10: check("t3 req b2b", 32'(imem_req), 32'd0);
            11: begin
               check("t3 addr b2b", 32'(imem_addr), 32'h200);
               check("t3 req b2b1", 32'(imem_req), 32'd1);
`ifdef FETCH_STATS_EN
               check("t3 flushed2", stat_flushed, 32'd8);
`endif
            end
            12: check("t3 valid b2b", 32'(instr_valid), 32'd0);
            13: check("t3 pc b2b", 32'(instr_pc), 32'h200);
            default: ;
         endcase
      end
      redirect = 1'b0;

      // 4: halt drains the in-flight entry and queue, then resumes sequentially
      start_run(1'b1);
      for (int k = 0; k < 10; k++) begin
         if (k > 0) @(negedge clk);
         halt = (k >= 3 && k <= 5);
         #1;
         case (k)
            3: begin
               check("t4 req halt", 32'(imem_req), 32'd0);
               check("t4 addr halt", 32'(imem_addr), 32'd3);
               check("t4 pc", 32'(instr_pc), 32'd1);
            end
            4: begin
               check("t4 inflight pushed", 32'(instr_pc), 32'd2);
               check("t4 halted early", 32'(halted), 32'd0);
            end
            5: begin
               check("t4 drained", 32'(instr_valid), 32'd0);
               check("t4 halted", 32'(halted), 32'd1);
            end
            6: check("t4 req release", 32'(imem_req), 32'd0);
            7: begin
               check("t4 resume req", 32'(imem_req), 32'd1);
               check("t4 resume addr", 32'(imem_addr), 32'd3);
               check("t4 halted off", 32'(halted), 32'd0);
            end
            8: check("t4 valid gap", 32'(instr_valid), 32'd0);
            9: check("t4 resume pc", 32'(instr_pc), 32'd3);
            default: ;
         endcase
      end
      halt = 1'b0;

      // 6: redirect together with halt, then asynchronous reset mid-burst
      start_run(1'b1);
      for (int k = 0; k < 8; k++) begin
         if (k > 0) @(negedge clk);
         redirect = (k == 3);
         redirect_pc = 16'h0080;
         halt = (k >= 3 && k <= 4);
         #1;
         case (k)
            3: check("t6 req", 32'(imem_req), 32'd0);
            4: begin
               check("t6 valid", 32'(instr_valid), 32'd0);
               check("t6 addr", 32'(imem_addr), 32'h80);
               check("t6 req halt", 32'(imem_req), 32'd0);
            end
            5: check("t6 req wait", 32'(imem_req), 32'd0);
            6: check("t6 addr go", 32'(imem_addr), 32'h80);
            7: check("t6 addr next", 32'(imem_addr), 32'h81);
            default: ;
         endcase
      end
      #1;
      rst = 1'b0;
      #1;
      check_reset_outputs("t6 async");
      check("t6 async addr", 32'(imem_addr), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("t6 after addr", 32'(imem_addr), 32'd0);
      check("t6 after req", 32'(imem_req), 32'd1);
      @(negedge clk);
      #1;
      check("t6 after valid", 32'(instr_valid), 32'd0);
      @(negedge clk);
      #1;
      check("t6 after pc", 32'(instr_pc), 32'd0);
      check("t6 after v2", 32'(instr_valid), 32'd1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
